// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - shared PLIC constants and gateway state type
// Ports: none (packages only)
//   constants : register byte offsets and default source count
//   wires     : gateway state enum shared by plic and plic_gateway
package constants;
  localparam int NSRC_DEFAULT = 8;

  // Byte offsets; the bus decodes only address bits [9:2].
  localparam logic [9:0] OFF_PRIORITY  = 10'h000;
  localparam logic [9:0] OFF_PENDING   = 10'h080;
  localparam logic [9:0] OFF_ENABLE    = 10'h100;
  localparam logic [9:0] OFF_THRESHOLD = 10'h200;
  localparam logic [9:0] OFF_CLAIM     = 10'h204;
endpackage

package wires;
  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PEND    = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_t;
endpackage

// File: rtl/plic_gateway.sv
// rtl/plic_gateway.sv - per-source level-sensitive interrupt gateway
// Ports:
//   clk      : clock
//   rst      : synchronous active-low reset
//   irq      : level-sensitive source line
//   claim    : one-cycle pulse, a claim read returned this source
//   complete : one-cycle pulse, complete was written with this source ID
//   pending  : high while the gateway sits in PEND
module plic_gateway
  import wires::*;
(
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  gw_state_t state;

  // While CLAIMED the source level is ignored; it is only looked at
  // again once complete has returned the gateway to IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= GW_IDLE;
    end else begin
      case (state)
        GW_IDLE:    if (irq)      state <= GW_PEND;
        GW_PEND:    if (claim)    state <= GW_CLAIMED;
        GW_CLAIMED: if (complete) state <= GW_IDLE;
        default:                  state <= GW_IDLE;
      endcase
    end
  end

  assign pending = (state == GW_PEND);

endmodule

// File: rtl/plic.sv
// rtl/plic.sv - platform interrupt controller: register bus, arbiter, gateways
// Ports:
//   rst         : synchronous active-low reset
//   clk         : clock
//   irq_src     : level interrupt lines, bit 0 unused
//   mem_valid   : bus request strobe
//   mem_wstrb   : nonzero = full-word write, zero = read
//   mem_addr    : byte address, bits [9:2] decoded
//   mem_wdata   : write data
//   mem_rdata   : read data, zero outside the response cycle
//   mem_ready   : one-cycle response pulse
//   extern_irpt : registered external interrupt request
module plic
  import constants::*;
#(
  parameter int NSRC  = NSRC_DEFAULT,
  parameter int PRIOW = 3
) (
  input  logic            rst,
  input  logic            clk,
  input  logic [NSRC-1:0] irq_src,
  input  logic            mem_valid,
  input  logic [3:0]      mem_wstrb,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  output logic [31:0]     mem_rdata,
  output logic            mem_ready,
  output logic            extern_irpt
);

  localparam int IDW = (NSRC > 2) ? $clog2(NSRC) : 1;

  localparam logic [7:0] W_PRIO  = OFF_PRIORITY[9:2];
  localparam logic [7:0] W_PEND  = OFF_PENDING[9:2];
  localparam logic [7:0] W_EN    = OFF_ENABLE[9:2];
  localparam logic [7:0] W_THR   = OFF_THRESHOLD[9:2];
  localparam logic [7:0] W_CLAIM = OFF_CLAIM[9:2];

  logic [PRIOW-1:0] prio [NSRC];
  logic [NSRC-1:0]  enable;
  logic [PRIOW-1:0] threshold;
  logic [NSRC-1:0]  pending;

  logic             accept;
  logic             wr;
  logic             rd;
  logic [7:0]       word;
  logic [7:0]       prio_idx;
  logic             prio_hit;
  logic             cmp_rd;
  logic             cmp_wr;
  logic [IDW-1:0]   win_id;
  logic [PRIOW-1:0] win_prio;
  logic [IDW-1:0]   claim_id;
  logic [31:0]      rd_val;

  // A request seen during the response cycle is dropped, not queued.
  assign accept   = mem_valid && !mem_ready;
  assign wr       = accept && (mem_wstrb != 4'b0);
  assign rd       = accept && (mem_wstrb == 4'b0);
  assign word     = mem_addr[9:2];
  assign prio_idx = word - W_PRIO;
  assign prio_hit = (32'(prio_idx) < 32'(NSRC));
  assign cmp_rd   = rd && (word == W_CLAIM);
  assign cmp_wr   = wr && (word == W_CLAIM);

  // Strict '>' keeps the earlier (lower) ID on equal priority; starting
  // from priority 0 excludes priority-0 sources from ever winning.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 1; i < NSRC; i++) begin
      if (pending[i] && enable[i] && (prio[i] > win_prio)) begin
        win_id   = IDW'(i);
        win_prio = prio[i];
      end
    end
  end

  assign claim_id = (win_prio > threshold) ? win_id : '0;

  always_comb begin
    rd_val = '0;
    if (prio_hit)                rd_val = 32'(prio[prio_idx[IDW-1:0]]);
    else if (word == W_PEND)     rd_val = 32'(pending);
    else if (word == W_EN)       rd_val = 32'(enable);
    else if (word == W_THR)      rd_val = 32'(threshold);
    else if (word == W_CLAIM)    rd_val = 32'(claim_id);
  end

  assign pending[0] = 1'b0;

  // A complete ID outside 1..NSRC-1 matches no gateway and so is dropped;
  // a gateway not in CLAIMED ignores its complete pulse by itself.
  for (genvar i = 1; i < NSRC; i++) begin : g_gw
    plic_gateway u_gw (
      .clk      (clk),
      .rst      (rst),
      .irq      (irq_src[i]),
      .claim    (cmp_rd && (claim_id == IDW'(i))),
      .complete (cmp_wr && (mem_wdata == 32'(i))),
      .pending  (pending[i])
    );
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (!rst || i == 0) begin
        prio[i] <= '0;
      end else if (wr && prio_hit && (prio_idx == 8'(i))) begin
        prio[i] <= mem_wdata[PRIOW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      extern_irpt <= 1'b0;
      enable      <= '0;
      threshold   <= '0;
    end else begin
      mem_ready   <= accept;
      mem_rdata   <= rd ? rd_val : '0;
      extern_irpt <= (win_prio > threshold);
      if (wr && (word == W_EN))  enable    <= {mem_wdata[NSRC-1:1], 1'b0};
      if (wr && (word == W_THR)) threshold <= mem_wdata[PRIOW-1:0];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{irq_src[0], mem_addr[31:10], mem_addr[1:0]};

endmodule

// File: doc/plic.md
PLIC -- requirements
Module: plic

Interface
REQ-001 SHALL have parameter NSRC, default 8, number of source IDs; ID 0 is reserved for "none" and sources are IDs 1..NSRC-1.
REQ-002 SHALL have parameter PRIOW, default 3, priority field width.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port irq_src  input  NSRC  level-sensitive interrupt lines; bit 0 is ignored.
REQ-006 SHALL have port mem_valid  input  1  bus request strobe.
REQ-007 SHALL have port mem_wstrb  input  4  byte strobes; nonzero means write, zero means read.
REQ-008 SHALL have port mem_addr  input  32  byte address; only bits [9:2] are decoded.
REQ-009 SHALL have port mem_wdata  input  32  write data.
REQ-010 SHALL have port mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-011 SHALL have port mem_ready  output  1  one-cycle response pulse.
REQ-012 SHALL have port extern_irpt  output  1  registered machine external interrupt request, driven to the CSR block.

Function
REQ-013 Register map offsets:
- 0x000+4*i: priority[i], PRIOW bits; priority[0] reads 0 and ignores writes.
- 0x080: pending vector, read-only.
- 0x100: enable vector; bit 0 reads 0.
- 0x200: threshold, PRIOW bits.
- 0x204: claim (read) / complete (write).
- Unmapped offsets read 0 and ignore writes.
REQ-014 Every write SHALL be a full-word write whenever mem_wstrb != 0; partial strobes are treated as full-word.
REQ-015 A request SHALL be accepted when mem_valid=1 and mem_ready=0.
REQ-016 mem_ready SHALL be 1 exactly one cycle after acceptance, then return to 0; mem_valid seen while mem_ready=1 is ignored.
REQ-017 mem_rdata SHALL be registered at acceptance and SHALL read 0 when mem_ready=0.
REQ-018 Each source SHALL have a gateway FSM with states IDLE, PEND and CLAIMED:
- IDLE -> PEND when irq_src[i]=1.
- PEND -> CLAIMED when a claim returns i.
- CLAIMED -> IDLE when complete is written with data equal to i.
- In CLAIMED, the level on irq_src[i] is ignored.
REQ-019 The pending bit of source i SHALL equal (state == PEND).
REQ-020 Arbitration candidates SHALL be sources that are pending, enabled and have priority > 0.
REQ-021 The winner SHALL be the highest-priority candidate; ties go to the lowest ID; with no candidate the winner is ID 0.
REQ-022 extern_irpt SHALL be registered and equal to (winner priority > threshold).
- Latency: irq_src rises in cycle N, pending is set in N+1, extern_irpt rises in N+2.
REQ-023 A claim read SHALL:
- return the winner of the acceptance cycle, or 0 if its priority <= threshold;
- move that source to CLAIMED on the same edge.
REQ-024 A claim that returns 0 SHALL change no state.
REQ-025 A complete write for a source not in CLAIMED, or with ID 0 or ID >= NSRC, SHALL be ignored.
REQ-026 Complete with the source level still high SHALL go CLAIMED -> IDLE, then -> PEND one cycle later.
REQ-027 Priority, enable and threshold writes SHALL take effect on arbitration from the next cycle.
REQ-028 If a source rises in the same cycle as a claim, the claim SHALL use the pre-edge pending state.

Reset
REQ-029 While rst=0 the block SHALL set:
- all gateways to IDLE;
- all priority, enable and threshold registers to 0;
- mem_ready=0, mem_rdata=0, extern_irpt=0.
REQ-030 Reset during an outstanding request SHALL drop the request with no mem_ready response.

Structure
REQ-031 The address offsets, the NSRC default and the gateway state enum SHALL be defined in the shared packages: offsets in constants, the enum typedef in wires.
REQ-032 The gateway SHALL be a sub-module named plic_gateway, instantiated NSRC-1 times; arbiter and bus logic SHALL stay in plic.

Verification
REQ-033 Set priority[3]=2, enable=0x08, threshold=0; pulse irq_src[3] high in cycle N -> extern_irpt=1 at N+2, claim read returns 3, extern_irpt=0 two cycles later.
REQ-034 Set priority[2]=5 and priority[5]=5, enable both, raise both sources -> first claim returns 2, second claim returns 5, third claim returns 0.
REQ-035 Set threshold=4 with priority[1]=4 pending -> extern_irpt stays 0 and claim returns 0; set threshold=3 -> extern_irpt=1 two cycles later.
REQ-036 Hold irq_src[6] high, claim 6, write complete=6 -> pending bit 6 reads 1 again; write complete=4 while 4 is not claimed -> no state change.
REQ-037 Apply rst=0 mid-request with a source pending -> mem_ready does not pulse, extern_irpt=0, all registers read 0 after reset.
